// File: rtl/uart_text_writer_if.sv
// Byte stream from the UART receiver plus the character-buffer write port
// driven by uart_text_writer.
interface uart_text_writer_if #(
  parameter int ADDR_W = 12
);
  logic              wr_i;
  logic [7:0]        data_i;
  logic              buf_we_o;
  logic [ADDR_W-1:0] buf_addr_o;
  logic [7:0]        buf_data_o;

  modport master (output wr_i, data_i, input buf_we_o, buf_addr_o, buf_data_o);
  modport slave  (input wr_i, data_i, output buf_we_o, buf_addr_o, buf_data_o);
endinterface

// File: rtl/uart_text_writer.sv
// Turns received UART bytes into VGA text-buffer writes with a cursor and CR/LF/BS/FF handling.
// Optional macro UART_TEXT_ROWCLR_EN: blank each newly entered row (ROWCLR state).
module uart_text_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  uart_text_writer_if.slave         bus,
  output logic [$clog2(COLS)-1:0]   col_o,
  output logic [$clog2(ROWS)-1:0]   row_o,
  output logic                      busy_o,
  output logic                      ovf_o
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] LAST_COLA = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS-1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS-1);

`ifdef UART_TEXT_ROWCLR_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_ROWCLR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;
`endif

  state_t            state_q, nxt_state;
  logic              wr_q;
  logic              pend_vld_q, nxt_pend_vld;
  logic [7:0]        pend_q, nxt_pend;
  logic              ovf_q, nxt_ovf;
  logic [CW-1:0]     col_q, nxt_col;
  logic [RW-1:0]     row_q, nxt_row;
  logic [ADDR_W-1:0] base_q, nxt_base;   // row_q*COLS, tracked instead of multiplied
  logic [ADDR_W-1:0] cnt_q, nxt_cnt;
  logic              we_q, nxt_we;
  logic [ADDR_W-1:0] addr_q, nxt_addr;
  logic [7:0]        data_q, nxt_data;
  logic              busy_q, nxt_busy;

  logic              cap, free, row_step;
  logic [ADDR_W-1:0] cur_addr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b1;
      pend_vld_q <= 1'b0;
      pend_q     <= 8'h00;
      ovf_q      <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= nxt_state;
      wr_q       <= bus.wr_i;
      pend_vld_q <= nxt_pend_vld;
      pend_q     <= nxt_pend;
      ovf_q      <= nxt_ovf;
      col_q      <= nxt_col;
      row_q      <= nxt_row;
      base_q     <= nxt_base;
      cnt_q      <= nxt_cnt;
      we_q       <= nxt_we;
      addr_q     <= nxt_addr;
      data_q     <= nxt_data;
      busy_q     <= nxt_busy;
    end
  end

  always_comb begin
    nxt_state    = state_q;
    nxt_pend_vld = pend_vld_q;
    nxt_pend     = pend_q;
    nxt_ovf      = ovf_q;
    nxt_col      = col_q;
    nxt_row      = row_q;
    nxt_base     = base_q;
    nxt_cnt      = cnt_q;
    nxt_we       = 1'b0;
    nxt_addr     = addr_q;
    nxt_data     = data_q;
    nxt_busy     = 1'b0;
    row_step     = 1'b0;
    cap          = bus.wr_i & ~wr_q;
    free         = (state_q == S_EXEC);
    cur_addr     = base_q + ADDR_W'(col_q);

    // EXEC releases the slot on this edge, so a byte landing now can take it
    if (free) nxt_pend_vld = 1'b0;
    if (cap) begin
      if (!pend_vld_q || free) begin
        nxt_pend_vld = 1'b1;
        nxt_pend     = bus.data_i;
      end else begin
        nxt_ovf = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (pend_vld_q) nxt_state = S_EXEC;
      S_EXEC: begin
        nxt_state = S_IDLE;
        if (pend_q >= 8'h20 && pend_q <= 8'h7E) begin
          nxt_we   = 1'b1;
          nxt_addr = cur_addr;
          nxt_data = pend_q;
          if (col_q == LAST_COL) begin
            nxt_col  = '0;
            row_step = 1'b1;
          end else begin
            nxt_col = col_q + CW'(1);
          end
        end else begin
          case (pend_q)
            8'h0D: nxt_col = '0;
            8'h0A: begin
              nxt_col  = '0;
              row_step = 1'b1;
            end
            8'h08: if (col_q != '0) begin
              nxt_col  = col_q - CW'(1);
              nxt_we   = 1'b1;
              nxt_addr = cur_addr - ADDR_W'(1);
              nxt_data = BLANK;
            end
            8'h0C: begin
              nxt_state = S_CLEAR;
              nxt_cnt   = '0;
            end
            default: ;
          endcase
        end
        if (row_step) begin
          nxt_row  = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
          nxt_base = (row_q == LAST_ROW) ? '0 : base_q + COLS_A;
`ifdef UART_TEXT_ROWCLR_EN
          nxt_state = S_ROWCLR;
          nxt_cnt   = '0;
`endif
        end
      end
      S_CLEAR: begin
        nxt_we   = 1'b1;
        nxt_busy = 1'b1;
        nxt_addr = cnt_q;
        nxt_data = BLANK;
        if (cnt_q == LAST_CELL) begin
          nxt_state = S_IDLE;
          nxt_col   = '0;
          nxt_row   = '0;
          nxt_base  = '0;
        end else begin
          nxt_cnt = cnt_q + ADDR_W'(1);
        end
      end
`ifdef UART_TEXT_ROWCLR_EN
      S_ROWCLR: begin
        // cursor already sits at (new row, 0); base_q points at that row
        nxt_we   = 1'b1;
        nxt_busy = 1'b1;
        nxt_addr = base_q + cnt_q;
        nxt_data = BLANK;
        if (cnt_q == LAST_COLA) nxt_state = S_IDLE;
        else                    nxt_cnt   = cnt_q + ADDR_W'(1);
      end
`endif
      default: nxt_state = S_IDLE;
    endcase
  end

  assign bus.buf_we_o   = we_q;
  assign bus.buf_addr_o = addr_q;
  assign bus.buf_data_o = data_q;
  assign col_o          = col_q;
  assign row_o          = row_q;
  assign busy_o         = busy_q;
  assign ovf_o          = ovf_q;
endmodule

// File: tb/tb_uart_text_writer.sv
// Directed bench for uart_text_writer: byte capture, cursor moves, control codes, clear and overflow.
module tb_uart_text_writer;
  localparam int COLS = 80, ROWS = 30, ADDR_W = 12;
`ifdef UART_TEXT_ROWCLR_EN
  localparam int RC = 1;
`else
  localparam int RC = 0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [6:0] col;
  logic [4:0] row;
  logic busy, ovf;

  always #5 clk = ~clk;

  uart_text_writer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(8'h20)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus),
    .col_o(col), .row_o(row), .busy_o(busy), .ovf_o(ovf)
  );

  int errs = 0, checks = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [7:0]        wd[$];
  logic              wb[$];

  always @(negedge clk) if (bus.buf_we_o === 1'b1) begin
    wa.push_back(bus.buf_addr_o);
    wd.push_back(bus.buf_data_o);
    wb.push_back(busy);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wa.delete(); wd.delete(); wb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wr_i = 1'b0; rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    clr_log();
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    bus.data_i = b; bus.wr_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.wr_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic quiet();
    int q = 0, n = 0;
    while (q < 4 && n < 6000) begin
      @(negedge clk);
      n++;
      if (!busy && !bus.buf_we_o) q++; else q = 0;
    end
    if (n >= 6000) chk("quiet_timeout", 1, 0);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(b);
    quiet();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n58, nbl;
    // reset with wr_i already high
    bus.wr_i = 1'b1; bus.data_i = 8'h41; rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", bus.buf_we_o, 0);
    chk("rst_addr", bus.buf_addr_o, 0);
    chk("rst_data", bus.buf_data_o, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_no_write", wa.size(), 0);
    bus.wr_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.wr_i = 1'b1;
    @(negedge clk); chk("lat_c1", bus.buf_we_o, 0);
    @(negedge clk); chk("lat_c2", bus.buf_we_o, 0);
    @(negedge clk); chk("lat_c3_we", bus.buf_we_o, 1);
    chk("lat_addr", bus.buf_addr_o, 0);
    chk("lat_data", bus.buf_data_o, 8'h41);
    repeat (2000) @(negedge clk);
    bus.wr_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_one_write", wa.size(), 1);
    chk("held_col", col, 1);

    // 81 printable bytes
    do_reset();
    for (int i = 0; i < 81; i++) send(8'h58);
    bad = 0; n58 = 0; nbl = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wd[i] == 8'h58) begin
        if (wa[i] != ADDR_W'(n58)) bad++;
        n58++;
      end else if (wd[i] == 8'h20) begin
        if (wa[i] != ADDR_W'(80 + nbl)) bad++;
        nbl++;
      end else bad++;
    end
    chk("x81_count", n58, 81);
    chk("x81_addr_bad", bad, 0);
    chk("x81_rowclr", nbl, RC*80);
    chk("x81_row", row, 1);
    chk("x81_col", col, 1);

    // last cell and wrap
    do_reset();
    for (int i = 0; i < 29; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h5A);
    chk("pre_wrap_row", row, 29);
    chk("pre_wrap_col", col, 79);
    clr_log();
    send(8'h42);
    chk("wrap_count", wa.size(), 1 + RC*80);
    if (wa.size() > 0) begin
      chk("wrap_addr", wa[0], 2399);
      chk("wrap_data", wd[0], 8'h42);
    end
    chk("wrap_row", row, 0);
    chk("wrap_col", col, 0);

    // backspace
    do_reset();
    send(8'h41); send(8'h42); send(8'h08); send(8'h08);
    chk("bs_col_mid", col, 0);
    send(8'h08);
    chk("bs_count", wa.size(), 4);
    if (wa.size() == 4) begin
      chk("bs_w0", {wa[0], wd[0]}, {12'd0, 8'h41});
      chk("bs_w1", {wa[1], wd[1]}, {12'd1, 8'h42});
      chk("bs_w2", {wa[2], wd[2]}, {12'd1, 8'h20});
      chk("bs_w3", {wa[3], wd[3]}, {12'd0, 8'h20});
    end
    chk("bs_col", col, 0);
    chk("bs_row", row, 0);
    chk("bs_ovf", ovf, 0);

    // form feed with bytes arriving mid-clear
    do_reset();
    send(8'h41);
    clr_log();
    pulse(8'h0C);
    chk("ff_busy", busy, 1);
    pulse(8'h43);
    pulse(8'h44);
    chk("ff_ovf_early", ovf, 1);
    quiet();
    chk("ff_count", wa.size(), 2401);
    bad = 0;
    for (int i = 0; i < 2400 && i < wa.size(); i++)
      if (wa[i] != ADDR_W'(i) || wd[i] != 8'h20 || wb[i] != 1'b1) bad++;
    chk("ff_blank_bad", bad, 0);
    if (wa.size() == 2401) chk("ff_after", {wa[2400], wd[2400]}, {12'd0, 8'h43});
    chk("ff_ovf", ovf, 1);
    chk("ff_col", col, 1);
    chk("ff_row", row, 0);
    chk("ff_busy_end", busy, 0);

    // non-writing codes
    do_reset();
    send(8'h0A);
    chk("lf_row", row, 1);
    chk("lf_col", col, 0);
    chk("lf_count", wa.size(), RC*80);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != ADDR_W'(80 + i) || wd[i] != 8'h20) bad++;
    chk("lf_rowclr_bad", bad, 0);
    send(8'h41);
    clr_log();
    send(8'h0D);
    chk("cr_col", col, 0);
    send(8'h07); send(8'hFF);
    chk("ign_count", wa.size(), 0);
    chk("ign_row", row, 1);
    chk("ign_col", col, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
